// File: rtl/filter_line_ctrl_5x5_pkg.sv
// Shared state encoding and line constants for the 5x5 filter line-memory controller.
package filter_line_ctrl_5x5_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StActive,
        StGap,
        StFlush,
        StDone
    } line_state_e;

    localparam int unsigned FlushGapDefault = 8;

    localparam logic [3:0] LineOneHot0 = 4'b0001;
    localparam logic [3:0] LineOneHot1 = 4'b0010;
    localparam logic [3:0] LineOneHot2 = 4'b0100;
    localparam logic [3:0] LineOneHot3 = 4'b1000;

    function automatic logic [3:0] line_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        unique case (idx)
            2'd0: oh = LineOneHot0;
            2'd1: oh = LineOneHot1;
            2'd2: oh = LineOneHot2;
            default: oh = LineOneHot3;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/filter_line_ctrl_5x5.sv
// Line-memory sequencer for a 5x5 filter: tracks raster position, drives line-memory
// read/write strobes and flushes two trailing lines after the last input line.
module filter_line_ctrl_5x5
    import filter_line_ctrl_5x5_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 11,
    parameter int unsigned FLUSH_GAP      = FlushGapDefault
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_frame_start,
    input  logic                      i_de,
    input  logic [MEM_ADDR_WIDTH-1:0] i_hsize,
    input  logic [MEM_ADDR_WIDTH-1:0] i_vsize,
    output logic                      o_input_de,
    output logic                      o_mem_de,
    output logic                      o_mem_y_ren,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr,
    output logic [3:0]                o_mem_y_wen,
    output logic [3:0]                o_aln_ln_y,
    output logic [3:0]                o_pad_ln_y,
    output logic [1:0]                o_mem_u_wen,
    output logic [1:0]                o_mem_u_ren,
    output logic [1:0]                o_mem_v_wen,
    output logic [1:0]                o_mem_v_ren,
    output logic                      o_busy,
    output logic                      o_frame_done
);
    localparam int unsigned AddrW = MEM_ADDR_WIDTH;
    // Line index runs to V+1 during the second flush line.
    localparam int unsigned LineW = MEM_ADDR_WIDTH + 1;
    localparam int unsigned GapW  = $clog2(FLUSH_GAP);

    line_state_e      r_state, w_state_nxt;
    logic [AddrW-1:0] r_hsize, r_vsize, w_hsize_nxt, w_vsize_nxt;
    logic [AddrW-1:0] r_col, w_col_nxt;
    logic [LineW-1:0] r_line, w_line_nxt;
    logic [GapW-1:0]  r_gap, w_gap_nxt;
    logic [3:0]       r_y_wen;
    logic [1:0]       r_uv_wen;
    logic [AddrW-1:0] r_waddr;

    logic             w_size_ok, w_start, w_accept, w_col_last;
    logic             w_read, w_flush, w_in_frame;
    logic [LineW-1:0] w_vsize_ext, w_row;
    logic [1:0]       w_wr_line;
    logic [AddrW-1:0] w_wr_col;

    assign w_size_ok   = (i_hsize >= AddrW'(3)) && (i_vsize >= AddrW'(4));
    assign w_start     = i_frame_start && w_size_ok;
    assign w_col_last  = (r_col == r_hsize - AddrW'(1));
    assign w_vsize_ext = {1'b0, r_vsize};
    // A pixel arriving with a frame start is pixel 0 of the new frame.
    assign w_accept    = i_de && (w_start || ((r_state == StActive) && !i_frame_start));
    assign w_wr_line   = i_frame_start ? 2'd0 : r_line[1:0];
    assign w_wr_col    = i_frame_start ? '0 : r_col;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= StIdle;
            r_hsize  <= '0;
            r_vsize  <= '0;
            r_col    <= '0;
            r_line   <= '0;
            r_gap    <= '0;
            r_y_wen  <= '0;
            r_uv_wen <= '0;
            r_waddr  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_hsize  <= w_hsize_nxt;
            r_vsize  <= w_vsize_nxt;
            r_col    <= w_col_nxt;
            r_line   <= w_line_nxt;
            r_gap    <= w_gap_nxt;
            r_y_wen  <= w_accept ? line_onehot(w_wr_line) : 4'b0000;
            r_uv_wen <= w_accept ? {w_wr_line == 2'd2, w_wr_line == 2'd0} : 2'b00;
            r_waddr  <= w_accept ? w_wr_col : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hsize_nxt = r_hsize;
        w_vsize_nxt = r_vsize;
        w_col_nxt   = r_col;
        w_line_nxt  = r_line;
        w_gap_nxt   = r_gap;
        if (i_frame_start) begin
            if (w_size_ok) begin
                w_state_nxt = StActive;
                w_hsize_nxt = i_hsize;
                w_vsize_nxt = i_vsize;
                w_line_nxt  = '0;
                w_col_nxt   = i_de ? AddrW'(1) : '0;
                w_gap_nxt   = '0;
            end else if (r_state != StIdle) begin
                w_state_nxt = StIdle;
                w_line_nxt  = '0;
                w_col_nxt   = '0;
                w_gap_nxt   = '0;
            end
        end else begin
            unique case (r_state)
                StActive: begin
                    if (i_de) begin
                        if (w_col_last) begin
                            w_col_nxt  = '0;
                            w_line_nxt = r_line + LineW'(1);
                            if (r_line == w_vsize_ext - LineW'(1)) begin
                                w_state_nxt = StGap;
                                w_gap_nxt   = '0;
                            end
                        end else begin
                            w_col_nxt = r_col + AddrW'(1);
                        end
                    end
                end
                StGap: begin
                    if (r_gap == GapW'(FLUSH_GAP - 1)) begin
                        w_state_nxt = StFlush;
                        w_gap_nxt   = '0;
                    end else begin
                        w_gap_nxt = r_gap + GapW'(1);
                    end
                end
                StFlush: begin
                    if (w_col_last) begin
                        w_col_nxt   = '0;
                        w_line_nxt  = r_line + LineW'(1);
                        w_state_nxt = (r_line == w_vsize_ext) ? StGap : StDone;
                    end else begin
                        w_col_nxt = r_col + AddrW'(1);
                    end
                end
                StDone: begin
                    w_state_nxt = StIdle;
                    w_line_nxt  = '0;
                    w_col_nxt   = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_in_frame   = (r_state == StActive) || (r_state == StGap) || (r_state == StFlush);
        w_read       = (r_state == StActive) && i_de && !i_frame_start && (r_line >= LineW'(2));
        w_flush      = (r_state == StFlush);
        w_row        = r_line - LineW'(2);
        o_input_de   = w_accept;
        o_mem_de     = w_read || w_flush;
        o_mem_y_ren  = w_read || w_flush;
        o_mem_u_ren  = {2{w_read}};
        o_mem_v_ren  = {2{w_read}};
        o_mem_raddr  = (w_read || w_flush) ? r_col : '0;
        o_aln_ln_y   = w_in_frame ? line_onehot(r_line[1:0]) : 4'b0000;
        o_pad_ln_y   = 4'b0000;
        // Output row r = n-2 selects the vertical padding case at the frame edges.
        if (w_in_frame && (r_line >= LineW'(2))) begin
            if (w_row == '0) begin
                o_pad_ln_y = 4'b0001;
            end else if (w_row == LineW'(1)) begin
                o_pad_ln_y = 4'b0010;
            end else if (w_row == w_vsize_ext - LineW'(2)) begin
                o_pad_ln_y = 4'b1000;
            end else if (w_row == w_vsize_ext - LineW'(1)) begin
                o_pad_ln_y = 4'b0100;
            end
        end
        o_mem_y_wen  = r_y_wen;
        o_mem_u_wen  = r_uv_wen;
        o_mem_v_wen  = r_uv_wen;
        o_mem_waddr  = r_waddr;
        o_busy       = (r_state != StIdle);
        o_frame_done = (r_state == StDone);
    end

endmodule
